uart_tx_stream: RTL and testbench



---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_stream_if.sv | 8 +
 rtl/uart_bit_timer.sv | 16 +
 rtl/uart_tx_stream.sv | 84 ++++++++
 tb/tb_uart_tx_stream.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types and constants.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: ready/valid byte stream feeding the UART transmitter.
interface uart_tx_stream_if import uart_pkg::*; ();
  logic                      recv_tvalid;
  logic                      recv_tready;
  logic [UART_DATA_BITS-1:0] recv_tdata;
  modport master (output recv_tvalid, output recv_tdata, input recv_tready);
  modport slave (input recv_tvalid, input recv_tdata, output recv_tready);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: down-counter pulsing bit_done on the last cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_done = cnt_q == '0;
  assign cnt_d = (restart || bit_done) ? TOP : cnt_q - 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: ready/valid byte stream to 8N1 UART TX, back-to-back frames without idle gap.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd chosen by PARITY_ODD).
module uart_tx_stream import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 100,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic clk,
  input  logic rst,
  uart_tx_stream_if.slave recv,
  output logic tx,
  output logic busy
);
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_stream: illegal parameter value");
  end
  uart_tx_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic tx_d, bit_done, last_stop, hs, par_bit;
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t AFTER_DATA = PARITY;
  logic par_q;
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : hs ? ^recv.recv_tdata ^ 1'(PARITY_ODD) : par_q;
  assign par_bit = par_q;
`else
  localparam uart_tx_state_t AFTER_DATA = STOP;
  assign par_bit = 1'b1;
`endif
  // tready opens on the final stop cycle so the next start bit follows with no gap
  assign last_stop = state_q == STOP && bit_done && idx_q == 3'(STOP_BITS - 1);
  assign recv.recv_tready = !rst && (state_q == IDLE || last_stop);
  assign hs = recv.recv_tvalid && recv.recv_tready;
  assign busy = state_q != IDLE;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .rst(rst), .restart(state_q == IDLE), .bit_done(bit_done)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    if (hs) begin
      state_d = START;
      shift_d = recv.recv_tdata;
      idx_d = '0;
    end else if (bit_done) begin
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          state_d = idx_q == 3'(UART_DATA_BITS - 1) ? AFTER_DATA : DATA;
          idx_d = idx_q == 3'(UART_DATA_BITS - 1) ? 3'd0 : idx_q + 3'd1;
        end
        PARITY: begin
          state_d = STOP;
          idx_d = '0;
        end
        STOP: begin
          state_d = last_stop ? IDLE : STOP;
          idx_d = idx_q + 3'd1;
        end
        default: ;
      endcase
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_bit : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      tx <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      tx <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed bench with a byte scoreboard decoding the 1-stop-bit DUT's line.
module tb_uart_tx_stream;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR1 = (10 + PB) * CPB;
  localparam int FR2 = (11 + PB) * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx1, busy1, tx2, busy2;
  int checks = 0, errors = 0, cyc = 0, frames1 = 0;
  logic [7:0] exp_q[$];
  uart_tx_stream_if s1();
  uart_tx_stream_if s2();
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .recv(s1), .tx(tx1), .busy(busy1)
  );
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .recv(s2), .tx(tx2), .busy(busy2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int c, input logic odd);
    int i;
    i = c / CPB;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PB == 1 && i == 9) return ^b ^ odd;
    return 1'b1;
  endfunction

  // returns on the first negedge after the handshake (frame cycle 0)
  task automatic send(input bit which, input logic [7:0] b, input bit keep, output int hs);
    int n = 0;
    if (which) begin s2.recv_tvalid = 1'b1; s2.recv_tdata = b; end
    else begin s1.recv_tvalid = 1'b1; s1.recv_tdata = b; end
    #1;
    while ((which ? s2.recv_tready : s1.recv_tready) !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("hs_wait", 32'(n < 200), 1);
    if (!which && n < 200) exp_q.push_back(b);
    @(negedge clk);
    hs = cyc;
    if (!keep) begin
      if (which) s2.recv_tvalid = 1'b0;
      else s1.recv_tvalid = 1'b0;
    end
  endtask

  task automatic frame2(input logic [7:0] b, output logic bad, output int rc);
    bad = 1'b0;
    rc = -1;
    for (int c = 0; c < FR2; c++) begin
      if (c > 0) @(negedge clk);
      if (tx2 !== exp_bit(b, c, 1'b1) || busy2 !== 1'b1) bad = 1'b1;
      if (s2.recv_tready === 1'b1 && rc < 0) rc = c;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 500), 1);
    @(negedge clk);
  endtask

  // scoreboard monitor: pops the expected byte at each start bit and checks the whole frame
  initial forever begin
    @(negedge clk);
    if (!rst && tx1 === 1'b0) begin : mon
      logic [7:0] b, dec;
      logic bad, ab;
      check("frame1_expected", 32'(exp_q.size() != 0), 1);
      b = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      bad = 1'b0;
      ab = 1'b0;
      dec = 8'h00;
      for (int c = 0; c < FR1; c++) begin
        if (c > 0) @(negedge clk);
        if (rst) begin ab = 1'b1; break; end
        if (tx1 !== exp_bit(b, c, 1'b0) || busy1 !== 1'b1) bad = 1'b1;
        if (c % CPB == 1 && c / CPB >= 1 && c / CPB <= 8) dec[c/CPB-1] = tx1;
      end
      if (!ab) begin
        frames1++;
        check("frame1_byte", 32'(dec), 32'(b));
        check("frame1_wave_ok", 32'(bad), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int h1, h2, n, rp, rc;
    logic bad;
    s1.recv_tvalid = 1'b0; s1.recv_tdata = 8'h00;
    s2.recv_tvalid = 1'b0; s2.recv_tdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx1", 32'(tx1), 1);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_ready1", 32'(s1.recv_tready), 0);
    check("rst_tx2", 32'(tx2), 1);
    rst = 1'b0;
    #1;
    check("idle_ready1", 32'(s1.recv_tready), 1);
    @(negedge clk);
    send(1'b0, 8'h55, 1'b0, h1);
    check("start_at_n1", 32'(tx1), 0);
    n = 1;
    rp = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      if (busy1) begin
        n++;
        rp += int'(s1.recv_tready);
      end
    end
    check("busy1_cycles", n, FR1);
    check("ready1_pulses", rp, 1);
    check("idle_tx1", 32'(tx1), 1);
    send(1'b0, 8'hA5, 1'b1, h1);
    send(1'b0, 8'h3C, 1'b0, h2);
    check("b2b_spacing1", h2 - h1, FR1);
    wait_idle();
    send(1'b0, 8'h07, 1'b0, h1);
    wait_idle();
    send(1'b1, 8'hFF, 1'b0, h1);
    frame2(8'hFF, bad, rc);
    check("stop2_wave_ok", 32'(bad), 0);
    check("ready2_first_cycle", rc, FR2 - 1);
    @(negedge clk);
    check("busy2_after_frame", 32'(busy2), 0);
    send(1'b1, 8'h07, 1'b0, h1);
    frame2(8'h07, bad, rc);
    check("frame2_07_wave_ok", 32'(bad), 0);
    wait_idle();
    send(1'b1, 8'hC3, 1'b1, h1);
    send(1'b1, 8'h3C, 1'b0, h2);
    check("b2b_spacing2", h2 - h1, FR2);
    wait_idle();
    send(1'b0, 8'hF0, 1'b0, h1);
    repeat (4 * CPB + 1) @(negedge clk);
    check("pre_rst_bit3", 32'(tx1), 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx1", 32'(tx1), 1);
    check("midrst_busy1", 32'(busy1), 0);
    check("midrst_ready1", 32'(s1.recv_tready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready1", 32'(s1.recv_tready), 1);
    @(negedge clk);
    send(1'b0, 8'h81, 1'b0, h1);
    wait_idle();
    rst = 1'b1;
    s1.recv_tvalid = 1'b1; s1.recv_tdata = 8'h00;
    s2.recv_tvalid = 1'b1; s2.recv_tdata = 8'h00;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (s1.recv_tready !== 1'b0 || s2.recv_tready !== 1'b0 || tx1 !== 1'b1 || tx2 !== 1'b1 ||
          busy1 !== 1'b0 || busy2 !== 1'b0) bad = 1'b1;
    end
    check("rst_hold_no_hs", 32'(bad), 0);
    s1.recv_tvalid = 1'b0;
    s2.recv_tvalid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_hold_busy1", 32'(busy1), 0);
    check("after_hold_tx1", 32'(tx1), 1);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("frames1_done", frames1, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
